// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and constants for the PWM peripheral.
package pwm_pkg;
  localparam int PWM_CNT_W = 8;
  localparam int NUM_CH = 16;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: free-running prescaler and 8-bit period counter with period strobes.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 wrap,
  output logic                 period_start
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic          first;
  assign tick = presc_cnt == PW'(CLK_DIV - 1);
  assign wrap = tick && pwm_cnt == '1;
  // first marks the clk right after reset release so it also opens a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      first        <= 1'b1;
      period_start <= 1'b0;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + PW'(1);
      pwm_cnt      <= tick ? pwm_cnt + PWM_CNT_W'(1) : pwm_cnt;
      first        <= 1'b0;
      period_start <= wrap || first;
    end
  end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 static/PWM channels sharing one period-aligned, double-buffered duty.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_start
);
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_q;
  logic [PWM_CNT_W-1:0] duty_eff;
  logic                 wrap;
  logic                 load_pend;
  logic                 pwm_sig;
  logic [NUM_CH-1:0]    en_out;
  logic [NUM_CH-1:0]    en_pwm;
  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  // shadow is transparent until its first load so the post-reset duty drives the very first period
  assign duty_eff = load_pend ? pwm_duty_cycle : duty_q;
  assign pwm_sig = (duty_eff == DUTY_FULL) || (pwm_cnt < duty_eff);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      load_pend <= 1'b1;
      out       <= '0;
    end else begin
      duty_q    <= (wrap || load_pend) ? pwm_duty_cycle : duty_q;
      load_pend <= 1'b0;
      out       <= en_out & (~en_pwm | {NUM_CH{pwm_sig}});
    end
  end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed checks of timebase, duty shadowing, reset and channel muxing.
module tb_pwm_peripheral;
  localparam int PER = 3328;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;
  int checks = 0;
  int errors = 0;

  pwm_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #50 clk = ~clk;

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ps;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 4000);
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_ps: period_start=%b after %0d clk, required 1", period_start, n);
    end
  endtask

  task automatic measure(input int ch, output int hi, output int ps_n, output logic first_v);
    hi = 0;
    ps_n = 0;
    first_v = 1'b0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == 0) first_v = out[ch];
      hi += int'(out[ch]);
      ps_n += int'(period_start);
    end
  endtask

  task automatic test_reset;
    set_en(16'h0000, 16'h0000);
    duty = 8'h10;
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h, required 0000", out); end
    checks++;
    if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b, required 0", period_start); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL reset_first_ps: got %b, required 1", period_start); end
    @(negedge clk);
    checks++;
    if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps_pulse: got %b, required 0", period_start); end
  endtask

  task automatic test_static;
    int bad = 0;
    set_en(16'h00FF, 16'h0000);
    @(negedge clk);
    checks++;
    if (out !== 16'h00FF) begin errors++; $display("FAIL static_latency: got %h, required 00ff", out); end
    repeat (2 * PER) begin
      @(negedge clk);
      if (out !== 16'h00FF) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL static_hold: %0d clk differed, required 0", bad); end
  endtask

  task automatic test_half;
    int hi, ps_n;
    logic first_v;
    set_en(16'h0001, 16'h0001);
    duty = 8'h80;
    wait_ps;
    wait_ps;
    checks++;
    if (out[0] !== 1'b0) begin errors++; $display("FAIL half_at_ps: out0=%b, required 0", out[0]); end
    measure(0, hi, ps_n, first_v);
    checks++;
    if (first_v !== 1'b1) begin errors++; $display("FAIL half_rise: out0=%b one clk after period_start, required 1", first_v); end
    checks++;
    if (hi != 1664) begin errors++; $display("FAIL half_high: %0d clk high, required 1664", hi); end
    checks++;
    if (period_start !== 1'b1 || ps_n != 1) begin
      errors++;
      $display("FAIL half_period: ps=%b strobes=%0d at clk %0d, required 1/1", period_start, ps_n, PER);
    end
  endtask

  task automatic test_extremes;
    int hi, tot, ps_n;
    logic first_v;
    duty = 8'h00;
    wait_ps;
    measure(0, hi, ps_n, first_v);
    checks++;
    if (hi != 0) begin errors++; $display("FAIL duty00: %0d clk high, required 0", hi); end
    duty = 8'hFF;
    wait_ps;
    tot = 0;
    repeat (3) begin
      measure(0, hi, ps_n, first_v);
      tot += hi;
    end
    checks++;
    if (tot != 3 * PER) begin errors++; $display("FAIL dutyFF: %0d clk high, required %0d", tot, 3 * PER); end
  endtask

  task automatic test_mid_update;
    int hi = 0;
    int ps_n;
    logic first_v;
    duty = 8'h40;
    wait_ps;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      if (i == 208) duty = 8'hC0;
      hi += int'(out[0]);
    end
    checks++;
    if (hi != 832) begin errors++; $display("FAIL mid_cur: %0d clk high, required 832", hi); end
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL mid_ps: got %b, required 1", period_start); end
    measure(0, hi, ps_n, first_v);
    checks++;
    if (hi != 2496) begin errors++; $display("FAIL mid_next: %0d clk high, required 2496", hi); end
  endtask

  task automatic test_reset_mid;
    int hi = 0;
    wait_ps;
    repeat (8'h7F * 13 + 1) @(negedge clk);
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre: out0=%b, required 1", out[0]); end
    rst_n = 1'b0;
    duty = 8'h60;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: out=%h ps=%b, required 0000/0", out, period_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (period_start !== 1'b1) begin errors++; $display("FAIL rmid_ps: got %b, required 1", period_start); end
      end
      hi += int'(out[0]);
    end
    checks++;
    if (hi != 1248) begin errors++; $display("FAIL rmid_duty: %0d clk high, required 1248", hi); end
  endtask

  task automatic test_mixed;
    int hi = 0;
    int bad_even = 0;
    int bad_odd = 0;
    set_en(16'hFFFF, 16'hAAAA);
    duty = 8'h20;
    wait_ps;
    repeat (PER) begin
      @(negedge clk);
      if ((out & 16'h5555) !== 16'h5555) bad_even++;
      if ((out & 16'hAAAA) !== 16'h0000 && (out & 16'hAAAA) !== 16'hAAAA) bad_odd++;
      hi += int'(out[1]);
    end
    checks++;
    if (bad_even != 0) begin errors++; $display("FAIL mixed_even: %0d clk not all high, required 0", bad_even); end
    checks++;
    if (bad_odd != 0) begin errors++; $display("FAIL mixed_odd_same: %0d clk disagreed, required 0", bad_odd); end
    checks++;
    if (hi != 416) begin errors++; $display("FAIL mixed_high: %0d clk high, required 416", hi); end
  endtask

  task automatic test_enable_immediate;
    repeat (700) @(negedge clk);
    set_en(16'h0000, 16'hAAAA);
    @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL en_off: got %h, required 0000", out); end
    set_en(16'h8001, 16'h0000);
    @(negedge clk);
    checks++;
    if (out !== 16'h8001) begin errors++; $display("FAIL en_on: got %h, required 8001", out); end
  endtask

  initial begin
    test_reset;
    test_static;
    test_half;
    test_extremes;
    test_mid_update;
    test_reset_mid;
    test_mixed;
    test_enable_immediate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
